// File: rtl/distance_sensor_core.sv
// Ultrasonic ranging core: fires a trigger pulse, times the echo high period,
// and repeats on a fixed period while enabled.
`timescale 1ns/1ps
module distance_sensor_core #(
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 3_000_000,
  parameter int PERIOD_CYCLES  = 6_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [31:0] echo_width,
  output logic        dist_valid,
  output logic        timeout,
  output logic        busy,
  output logic [15:0] meas_cnt
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t      state_q, state_d;
  logic        echo_meta_q, echo_s_q, echo_s_dly_q;
  logic        trig_q, trig_d;
  logic [31:0] trig_cnt_q, trig_cnt_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] timeout_cnt_q, timeout_cnt_d;
  logic [31:0] width_cnt_q, width_cnt_d;
  logic [31:0] echo_width_q, echo_width_d;
  logic        dist_valid_q, dist_valid_d;
  logic        timeout_q, timeout_d;
  logic [15:0] meas_cnt_q, meas_cnt_d;
  logic        fall_pend_q, fall_pend_d;
  logic        echo_rise, trig_done, timeout_hit, period_done;

  assign echo_rise   = echo_s_q & ~echo_s_dly_q;
  assign trig_done   = (trig_cnt_q == 32'(TRIG_CYCLES - 1));
  assign timeout_hit = (timeout_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign period_done = (period_cnt_q == 32'(PERIOD_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      echo_meta_q   <= 1'b0;
      echo_s_q      <= 1'b0;
      echo_s_dly_q  <= 1'b0;
      trig_q        <= 1'b0;
      trig_cnt_q    <= '0;
      period_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      width_cnt_q   <= '0;
      echo_width_q  <= '0;
      dist_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
      meas_cnt_q    <= '0;
      fall_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      echo_meta_q   <= echo;
      echo_s_q      <= echo_meta_q;
      echo_s_dly_q  <= echo_s_q;
      trig_q        <= trig_d;
      trig_cnt_q    <= trig_cnt_d;
      period_cnt_q  <= period_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      width_cnt_q   <= width_cnt_d;
      echo_width_q  <= echo_width_d;
      dist_valid_q  <= dist_valid_d;
      timeout_q     <= timeout_d;
      meas_cnt_q    <= meas_cnt_d;
      fall_pend_q   <= fall_pend_d;
    end
  end

  // A pending echo fall always completes; otherwise timeout wins over a fall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (enable) state_d = TRIG;
      TRIG:      if (trig_done) state_d = WAIT_RISE;
      WAIT_RISE: begin
        if (timeout_hit)    state_d = HOLDOFF;
        else if (echo_rise) state_d = MEASURE;
      end
      MEASURE:   if (fall_pend_q || timeout_hit) state_d = HOLDOFF;
      HOLDOFF:   if (period_done) state_d = enable ? TRIG : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    trig_d        = (state_d == TRIG);
    trig_cnt_d    = (state_q == TRIG && state_d == TRIG) ? trig_cnt_q + 32'd1 : '0;
    period_cnt_d  = period_cnt_q + 32'd1;
    timeout_cnt_d = '0;
    width_cnt_d   = width_cnt_q;
    echo_width_d  = echo_width_q;
    dist_valid_d  = 1'b0;
    timeout_d     = timeout_q;
    meas_cnt_d    = meas_cnt_q;
    fall_pend_d   = 1'b0;
    busy          = (state_q != IDLE);

    if ((state_d == TRIG && state_q != TRIG) || state_d == IDLE)
      period_cnt_d = '0;
    if (state_q == WAIT_RISE || state_q == MEASURE)
      timeout_cnt_d = timeout_cnt_q + 32'd1;

    case (state_q)
      WAIT_RISE: begin
        if (timeout_hit)    timeout_d   = 1'b1;
        else if (echo_rise) width_cnt_d = 32'd1;
      end
      MEASURE: begin
        if (fall_pend_q) begin
          dist_valid_d = 1'b1;
          timeout_d    = 1'b0;
          meas_cnt_d   = meas_cnt_q + 16'd1;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
        end else if (!echo_s_q) begin
          echo_width_d = width_cnt_q;
          fall_pend_d  = 1'b1;
        end else if (width_cnt_q != '1) begin
          width_cnt_d = width_cnt_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  assign trig       = trig_q;
  assign echo_width = echo_width_q;
  assign dist_valid = dist_valid_q;
  assign timeout    = timeout_q;
  assign meas_cnt   = meas_cnt_q;

endmodule

// File: tb/tb_distance_sensor_core.sv
// Directed bench for distance_sensor_core with a scoreboard of expected
// measurements popped on every dist_valid pulse.
`timescale 1ns/1ps
module tb_distance_sensor_core;
  localparam int TRIG_C = 10;
  localparam int TO_C   = 200;
  localparam int PER_C  = 400;

  logic        clock = 1'b0;
  logic        reset, enable, echo;
  logic        trig, dist_valid, timeout, busy;
  logic [31:0] echo_width;
  logic [15:0] meas_cnt;

  distance_sensor_core #(.TRIG_CYCLES(TRIG_C), .TIMEOUT_CYCLES(TO_C), .PERIOD_CYCLES(PER_C)) dut (
    .clock(clock), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .echo_width(echo_width), .dist_valid(dist_valid), .timeout(timeout),
    .busy(busy), .meas_cnt(meas_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {logic [31:0] width; logic [15:0] cnt;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] exp_cnt = 16'd0;

  int cyc = 0;
  int checks = 0, errors = 0;
  int valid_cnt = 0, trig_falls = 0, timeout_rises = 0;
  int rise_cyc[$];
  int last_rise_cyc = 0, last_fall_cyc = 0, last_to_cyc = 0;
  logic trig_prev = 1'b0, to_prev = 1'b0, dv_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: records trigger/timeout edge times and scores measurements.
  always @(negedge clock) begin
    if (trig === 1'b1 && !trig_prev) begin
      rise_cyc.push_back(cyc);
      last_rise_cyc = cyc;
    end
    if (trig === 1'b0 && trig_prev) begin
      trig_falls++;
      last_fall_cyc = cyc;
      checkOutput("trig_width", 32'(cyc - last_rise_cyc), TRIG_C);
    end
    if (timeout === 1'b1 && !to_prev) begin
      timeout_rises++;
      last_to_cyc = cyc;
    end
    if (dist_valid === 1'b1) begin
      valid_cnt++;
      checkOutput("dv_single", {31'd0, dv_prev}, 0);
      if (sb.size() == 0) begin
        checkOutput("dv_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("echo_width", echo_width, mon_e.width);
        checkOutput("meas_cnt", {16'd0, meas_cnt}, {16'd0, mon_e.cnt});
        checkOutput("timeout_clear", {31'd0, timeout}, 0);
      end
    end
    trig_prev = (trig === 1'b1);
    to_prev   = (timeout === 1'b1);
    dv_prev   = (dist_valid === 1'b1);
  end

  task automatic waitTrigFalls(input int target);
    int n = 0;
    while (trig_falls < target && n < 2000) begin @(negedge clock); n++; end
    checkOutput("wait_trig_fall", {31'd0, trig_falls >= target}, 1);
  endtask

  task automatic waitValid(input int target);
    int n = 0;
    while (valid_cnt < target && n < 2000) begin @(negedge clock); n++; end
    checkOutput("wait_valid", {31'd0, valid_cnt >= target}, 1);
  endtask

  task automatic waitTimeout(input int target);
    int n = 0;
    while (timeout_rises < target && n < 2000) begin @(negedge clock); n++; end
    @(negedge clock);
    checkOutput("wait_timeout", {31'd0, timeout_rises >= target}, 1);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin @(negedge clock); n++; end
    checkOutput("wait_idle", {31'd0, busy}, 0);
  endtask

  // Waits for the given trigger fall, then drives one echo pulse (width 0 = none).
  task automatic applyStimulus(input int fall_idx, input int delay, input int width,
                               input bit push, input int drop_at);
    exp_t e;
    waitTrigFalls(fall_idx);
    if (push) begin
      exp_cnt  = exp_cnt + 16'd1;
      e.width  = 32'(width);
      e.cnt    = exp_cnt;
      sb.push_back(e);
    end
    repeat (delay) @(negedge clock);
    if (width > 0) begin
      echo = 1'b1;
      for (int i = 0; i < width; i++) begin
        if (i == drop_at) enable = 1'b0;
        @(negedge clock);
      end
      echo = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_trig",       {31'd0, trig}, 0);
    checkOutput("rst_echo_width", echo_width, 0);
    checkOutput("rst_dist_valid", {31'd0, dist_valid}, 0);
    checkOutput("rst_timeout",    {31'd0, timeout}, 0);
    checkOutput("rst_busy",       {31'd0, busy}, 0);
    checkOutput("rst_meas_cnt",   {16'd0, meas_cnt}, 0);
    reset = 1'b0;
    @(negedge clock);

    enable = 1'b1;
    applyStimulus(1, 20, 50, 1'b1, -1);
    waitValid(1);
    checkOutput("m1_meas_cnt", {16'd0, meas_cnt}, 1);
    checkOutput("m1_timeout",  {31'd0, timeout}, 0);

    applyStimulus(2, 0, 0, 1'b0, -1);
    waitTimeout(1);
    checkOutput("to_delay",      32'(last_to_cyc - last_fall_cyc), TO_C);
    checkOutput("to_flag",       {31'd0, timeout}, 1);
    checkOutput("to_no_valid",   32'(valid_cnt), 1);
    checkOutput("to_width_kept", echo_width, 50);
    checkOutput("to_cnt_kept",   {16'd0, meas_cnt}, 1);

    applyStimulus(3, 20, 40, 1'b1, -1);
    waitValid(2);
    checkOutput("gap_1_2", 32'(rise_cyc[1] - rise_cyc[0]), PER_C);
    checkOutput("gap_2_3", 32'(rise_cyc[2] - rise_cyc[1]), PER_C);
    checkOutput("m3_timeout", {31'd0, timeout}, 0);

    applyStimulus(4, 20, 30, 1'b1, -1);
    waitValid(3);
    checkOutput("gap_3_4", 32'(rise_cyc[3] - rise_cyc[2]), PER_C);

    applyStimulus(5, 20, 70, 1'b1, 30);
    waitValid(4);
    checkOutput("gap_4_5", 32'(rise_cyc[4] - rise_cyc[3]), PER_C);
    checkOutput("holdoff_busy", {31'd0, busy}, 1);
    waitIdle();
    repeat (500) @(negedge clock);
    checkOutput("no_trig_after_disable", 32'(rise_cyc.size()), 5);
    checkOutput("idle_busy", {31'd0, busy}, 0);

    enable = 1'b1;
    waitTrigFalls(6);
    repeat (20) @(negedge clock);
    echo = 1'b1;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid_rst_trig",       {31'd0, trig}, 0);
    checkOutput("mid_rst_echo_width", echo_width, 0);
    checkOutput("mid_rst_dist_valid", {31'd0, dist_valid}, 0);
    checkOutput("mid_rst_timeout",    {31'd0, timeout}, 0);
    checkOutput("mid_rst_busy",       {31'd0, busy}, 0);
    checkOutput("mid_rst_meas_cnt",   {16'd0, meas_cnt}, 0);
    enable = 1'b0;
    echo = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    checkOutput("post_rst_valid_cnt", 32'(valid_cnt), 4);
    checkOutput("post_rst_busy",      {31'd0, busy}, 0);
    checkOutput("sb_drained",         32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
